// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: two-requester round-robin front end for a shared serial
// pattern detector. A granted request word is streamed MSB first into the
// detector, match flags are counted (saturating), and a one-cycle result
// pulse reports the requester id and match count.
//
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   req0/req1          request lines, held until the matching gnt pulse
//   data0/data1        request words (stream is data[len-1:0], MSB first)
//   len0/len1          stream length in bits, clipped to DW
//   gnt0/gnt1          one-cycle grant; data/len sampled in that cycle
//   det_rst, det_in    detector reset and serial bit
//   det_out            registered detector match flag
//   done               one-cycle result-valid pulse
//   res_id/cnt/hit     served requester, match count, count != 0
module seq_scan_ctrl #(
  parameter int unsigned DW = 16  // len is 5 bits, so DW must stay <= 31
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  input  logic [4:0]    len0,
  input  logic [4:0]    len1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          det_rst,
  output logic          det_in,
  input  logic          det_out,
  output logic          done,
  output logic          res_id,
  output logic [3:0]    res_cnt,
  output logic          res_hit
);

  localparam int unsigned CW = 4;
  localparam int unsigned IW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [4:0] LenMax = 5'(DW);
  localparam logic [CW-1:0] CntMax = '1;

  typedef enum logic [2:0] {StIdle, StClear, StShift, StDrain, StDone} state_e;

  state_e        state_q;
  logic [DW-1:0] data_q;
  logic [IW-1:0] idx_q;    // index of the bit currently on det_in
  logic          zero_q;   // effective length is zero
  logic          id_q;
  logic          prio_q;   // 1: req1 wins a tie
  logic          first_q;  // first SHIFT cycle, det_out not yet meaningful
  logic [CW-1:0] cnt_q;

  logic          pick1;
  logic          gnt_any;
  logic [DW-1:0] data_sel;
  logic [4:0]    len_sel;
  logic [4:0]    len_eff;
  logic [CW-1:0] cnt_inc;

  always_comb begin
    pick1    = (req0 && req1) ? prio_q : req1;
    // Gate with reset so no grant escapes while reset is asserted.
    gnt_any  = reset && (state_q == StIdle) && (req0 || req1);
    data_sel = pick1 ? data1 : data0;
    len_sel  = pick1 ? len1 : len0;
    len_eff  = (len_sel > LenMax) ? LenMax : len_sel;
    cnt_inc  = (det_out && (cnt_q != CntMax)) ? cnt_q + CW'(1) : cnt_q;
  end

  // Grant is combinational so it lands in the cycle the request is seen in IDLE.
  assign gnt0 = gnt_any && !pick1;
  assign gnt1 = gnt_any && pick1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      idx_q   <= '0;
      zero_q  <= 1'b0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
      first_q <= 1'b0;
      cnt_q   <= '0;
      det_rst <= 1'b0;
      det_in  <= 1'b0;
      done    <= 1'b0;
      res_id  <= 1'b0;
      res_cnt <= '0;
      res_hit <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gnt_any) begin
            data_q  <= data_sel;
            idx_q   <= IW'(len_eff - 5'd1);
            zero_q  <= (len_eff == 5'd0);
            id_q    <= pick1;
            prio_q  <= !pick1;
            cnt_q   <= '0;
            det_rst <= 1'b1;
            state_q <= StClear;
          end
        end
        StClear: begin
          det_rst <= 1'b0;
          if (zero_q) begin
            done    <= 1'b1;
            res_id  <= id_q;
            res_cnt <= cnt_q;
            res_hit <= (cnt_q != '0);
            state_q <= StDone;
          end else begin
            det_in  <= data_q[idx_q];
            first_q <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          first_q <= 1'b0;
          // det_out lags det_in by one cycle, so the first SHIFT cycle is skipped.
          if (!first_q) cnt_q <= cnt_inc;
          if (idx_q == '0) begin
            det_in  <= 1'b0;
            state_q <= StDrain;
          end else begin
            idx_q  <= idx_q - IW'(1);
            det_in <= data_q[idx_q - IW'(1)];
          end
        end
        StDrain: begin
          // Last bit's match flag arrives here; fold it straight into the result.
          done    <= 1'b1;
          res_id  <= id_q;
          res_cnt <= cnt_inc;
          res_hit <= (cnt_inc != '0);
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl with a behavioural 110011 detector.
module tb_seq_scan_ctrl;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic [DW-1:0] data0 = '0;
  logic [DW-1:0] data1 = '0;
  logic [4:0]    len0 = '0;
  logic [4:0]    len1 = '0;
  logic          gnt0, gnt1, det_rst, det_in, done, res_id, res_hit;
  logic [3:0]    res_cnt;
  logic          det_out = 1'b0;
  logic [5:0]    sr = '0;
  logic          force_det = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drst_cnt = 0;
  int din_cnt = 0;
  int both_gnt = 0;

  seq_scan_ctrl #(.DW(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .req1    (req1),
    .data0   (data0),
    .data1   (data1),
    .len0    (len0),
    .len1    (len1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .det_rst (det_rst),
    .det_in  (det_in),
    .det_out (det_out),
    .done    (done),
    .res_id  (res_id),
    .res_cnt (res_cnt),
    .res_hit (res_hit)
  );

  always #5 clk = ~clk;

  // Detector model: registered flag one cycle after the final bit of 110011.
  always @(posedge clk) begin
    if (force_det) begin
      det_out <= 1'b1;
    end else if (det_rst) begin
      sr      <= '0;
      det_out <= 1'b0;
    end else begin
      sr      <= {sr[4:0], det_in};
      det_out <= ({sr[4:0], det_in} == 6'b110011);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (gnt0 && gnt1) both_gnt <= both_gnt + 1;
    if (det_rst) drst_cnt <= drst_cnt + 1;
    if (det_in) din_cnt <= din_cnt + 1;
  end

  typedef struct {
    logic        r0;
    logic        r1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [4:0]  l0;
    logic [4:0]  l1;
    logic        frc;
    logic        exp_g1;
    logic [3:0]  exp_cnt;
    int          exp_lat;
    int          exp_din;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int limit);
    int w = 0;
    while (!done && w < limit) begin
      @(negedge clk);
      #1;
      w++;
    end
  endtask

  task automatic scan(input vec_t v, input string name);
    int          t;
    int          w;
    logic [31:0] exp_res;
    @(negedge clk);
    force_det = v.frc;
    req0 = v.r0;
    req1 = v.r1;
    data0 = v.d0;
    data1 = v.d1;
    len0 = v.l0;
    len1 = v.l1;
    #1;
    w = 0;
    while (!(gnt0 || gnt1) && w < 10) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk({name, "_gnt"}, 32'({gnt0, gnt1}), v.exp_g1 ? 32'h1 : 32'h2);
    t = cyc;
    drst_cnt = 0;
    din_cnt = 0;
    @(negedge clk);
    // Scramble inputs mid-scan; the scan must use the values latched at grant.
    req0 = 1'b0;
    req1 = 1'b0;
    data0 = ~v.d0;
    data1 = ~v.d1;
    len0 = ~v.l0;
    len1 = ~v.l1;
    #1;
    wait_done(40);
    chk({name, "_lat"}, 32'(cyc - t), 32'(v.exp_lat));
    exp_res = 32'({v.exp_g1, v.exp_cnt, (v.exp_cnt != 4'd0)});
    chk({name, "_res"}, 32'({res_id, res_cnt, res_hit}), exp_res);
    chk({name, "_drst"}, 32'(drst_cnt), 32'h1);
    chk({name, "_din"}, 32'(din_cnt), 32'(v.exp_din));
    @(negedge clk);
    #1;
    chk({name, "_hold"}, 32'({done, res_id, res_cnt, res_hit}), exp_res);
    force_det = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int t;
    //            r0    r1    d0        d1        l0     l1     frc   g1    cnt    lat din
    vecs[0]  = '{1'b1, 1'b1, 16'hCCCC, 16'h0033, 5'd16, 5'd6,  1'b0, 1'b0, 4'd3,  19, 8};
    vecs[1]  = '{1'b1, 1'b0, 16'h0033, 16'h0000, 5'd6,  5'd0,  1'b0, 1'b0, 4'd1,  9,  4};
    vecs[2]  = '{1'b0, 1'b1, 16'h0000, 16'h0333, 5'd0,  5'd10, 1'b0, 1'b1, 4'd2,  13, 6};
    vecs[3]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 5'd0,  5'd0,  1'b0, 1'b0, 4'd0,  2,  0};
    vecs[4]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 5'd20, 5'd0,  1'b0, 1'b0, 4'd0,  19, 16};
    vecs[5]  = '{1'b1, 1'b1, 16'h0333, 16'h0033, 5'd10, 5'd6,  1'b0, 1'b1, 4'd1,  9,  4};
    vecs[6]  = '{1'b1, 1'b1, 16'h0333, 16'h0033, 5'd10, 5'd6,  1'b0, 1'b0, 4'd2,  13, 6};
    vecs[7]  = '{1'b0, 1'b1, 16'h0000, 16'hCCCC, 5'd0,  5'd31, 1'b0, 1'b1, 4'd3,  19, 8};
    vecs[8]  = '{1'b1, 1'b0, 16'h8033, 16'h0000, 5'd17, 5'd0,  1'b0, 1'b0, 4'd1,  19, 5};
    vecs[9]  = '{1'b1, 1'b0, 16'h0033, 16'h0000, 5'd6,  5'd0,  1'b1, 1'b0, 4'd6,  9,  4};
    vecs[10] = '{1'b1, 1'b0, 16'hCCCC, 16'h0000, 5'd16, 5'd0,  1'b1, 1'b0, 4'd15, 19, 8};
    vecs[11] = '{1'b0, 1'b1, 16'h0000, 16'h0001, 5'd0,  5'd1,  1'b0, 1'b1, 4'd0,  4,  1};
    vecs[12] = '{1'b1, 1'b1, 16'h0033, 16'h0333, 5'd6,  5'd10, 1'b0, 1'b0, 4'd1,  9,  4};

    // Both requesting straight out of reset: req0 first, then req1.
    reset = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    data0 = 16'h0033;
    len0 = 5'd6;
    data1 = 16'h0333;
    len1 = 5'd10;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs",
        32'({gnt0, gnt1, det_rst, det_in, done, res_id, res_cnt, res_hit}), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rr_first_gnt", 32'({gnt0, gnt1}), 32'h2);
    t = cyc;
    drst_cnt = 0;
    @(negedge clk);
    req0 = 1'b0;
    #1;
    wait_done(40);
    chk("rr_first_lat", 32'(cyc - t), 32'd9);
    chk("rr_first_res", 32'({res_id, res_cnt, res_hit}), 32'({1'b0, 4'd1, 1'b1}));
    @(negedge clk);
    #1;
    chk("rr_second_gnt", 32'({gnt0, gnt1, done}), 32'h2);
    t = cyc;
    @(negedge clk);
    req1 = 1'b0;
    #1;
    wait_done(40);
    chk("rr_second_lat", 32'(cyc - t), 32'd13);
    chk("rr_second_res", 32'({res_id, res_cnt, res_hit}), 32'({1'b1, 4'd2, 1'b1}));
    chk("rr_drst_two", 32'(drst_cnt), 32'd2);

    for (int i = 0; i < 12; i++) begin
      scan(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset pulsed mid-SHIFT: outputs drop at once, round-robin pointer resets.
    @(negedge clk);
    req0 = 1'b1;
    data0 = 16'hCCCC;
    len0 = 5'd16;
    #1;
    chk("mid_gnt", 32'({gnt0, gnt1}), 32'h2);
    repeat (4) @(negedge clk);
    req1 = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("mid_reset_zero",
        32'({gnt0, gnt1, det_rst, det_in, done, res_id, res_cnt, res_hit}), 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("mid_reset_held",
        32'({gnt0, gnt1, det_rst, det_in, done, res_id, res_cnt, res_hit}), 32'h0);
    req0 = 1'b0;
    req1 = 1'b0;
    reset = 1'b1;
    scan(vecs[12], "post_reset");

    chk("gnt_exclusive", 32'(both_gnt), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameter: DW, 16, request word width in bits; CW = 4 is the fixed match-count width.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 req0, req1  input  1 each  request lines; held high until the matching gnt pulse.
REQ-005 data0, data1  input  DW each  request words; the bit stream is data[len-1:0], sent MSB first.
REQ-006 len0, len1  input  5 each  stream length in bits.
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant pulse; data/len are sampled in that cycle.
REQ-008 det_rst  output  1  drives the shared pattern detector's active-high reset.
REQ-009 det_in  output  1  serial bit to the detector.
REQ-010 det_out  input  1  detector match flag, registered, valid one cycle after the final bit of 110011 (overlapping).
REQ-011 done  output  1  one-cycle result-valid pulse.
REQ-012 res_id  output  1  requester served (0/1).
REQ-013 res_cnt  output  CW  matches counted.
REQ-014 res_hit  output  1  res_cnt != 0.

Function
REQ-015 The FSM SHALL have exactly five states: IDLE, CLEAR, SHIFT, DRAIN, DONE.
REQ-016 In IDLE with no request asserted, the FSM SHALL remain in IDLE.
REQ-017 In IDLE with any request asserted, the block SHALL:
- pulse the winner's gnt for that cycle;
- latch the winner's data, len and id;
- clear the match count;
- go to CLEAR.
REQ-018 Arbitration SHALL be round-robin:
- a single requester always wins;
- when both request, the requester not granted last wins;
- after reset, req0 has priority.
REQ-019 CLEAR SHALL last one cycle with det_rst=1 and det_in=0, then go to SHIFT; when the effective length is 0 it SHALL go to DONE instead.
REQ-020 Effective length SHALL be len clipped to DW: values 17..31 SHALL be treated as 16.
REQ-021 SHIFT SHALL present one bit per cycle on det_in, starting with data[len-1] and decrementing, for exactly len cycles.
REQ-022 After the last bit, SHIFT SHALL go to DRAIN.
REQ-023 det_out SHALL be counted in every SHIFT cycle except the first, and in the single DRAIN cycle.
REQ-024 DRAIN SHALL drive det_in=0 for one cycle, then go to DONE.
REQ-025 The match count SHALL saturate at 15, never wrap.
REQ-026 DONE SHALL last one cycle and then return to IDLE, during which:
- done=1;
- res_id, res_cnt and res_hit are driven from the latched and counted values.
REQ-027 res_id/res_cnt/res_hit SHALL hold their values until the next DONE.
REQ-028 The FSM SHALL accept no new grant before returning to IDLE; requests arriving during a scan wait.
REQ-029 Latency SHALL be: grant in cycle t, done in cycle t+len+3 (t+2 for len=0).
REQ-030 Outside CLEAR, det_rst SHALL be 0.
REQ-031 Outside SHIFT, det_in SHALL be 0.
REQ-032 gnt0 and gnt1 SHALL never be high in the same cycle.
REQ-033 Changes on req/data/len outside the grant cycle SHALL NOT affect the scan in progress.

Reset
REQ-034 While reset=0, the FSM SHALL be in IDLE and all outputs SHALL be 0: gnt0/1, det_rst, det_in, done, res_id, res_cnt, res_hit.
REQ-035 While reset=0, the round-robin pointer SHALL select req0 and the count SHALL be 0.
REQ-036 Reset asserted mid-scan SHALL abort the scan immediately, with no done pulse.
REQ-037 After reset is released, the first request SHALL restart from CLEAR.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- req0, data0=0x0033, len0=6 (bits 110011) -> gnt0 at t, done at t+9, res_id=0, res_cnt=1, res_hit=1.
- req1, data1=0x0333, len1=10 (1100110011, overlap) -> res_id=1, res_cnt=2, done at t+13.
- req0 and req1 both high from reset -> gnt0 first, gnt1 on the first IDLE after done; then both again -> gnt0.
- len0=0 -> done at t+2, res_cnt=0, res_hit=0; len0=20 with data0=0xFFFF -> exactly 16 SHIFT cycles, res_cnt=0.
- reset=0 pulsed during SHIFT -> all outputs 0 at once, no done; next request scans correctly from CLEAR.
- data0=0xCCCC, len0=16 -> res_cnt=3; det_rst high exactly one cycle per request.
